// File: rtl/image_frame_loader.sv
// Serial 1-bit pixel loader that assembles a 32x32 binary image, then resets
// and runs the TPU and latches the classified digit (or a timeout marker).
module image_frame_loader #(
    parameter int IMG_PIX     = 1024,
    parameter int TPU_RST_CYC = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic               clk,
    input  logic               iRst,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic               pix_data,
    input  logic               pix_sof,
    output logic [IMG_PIX-1:0] image_out,
    output logic               tpu_ena,
    output logic               tpu_rst_n,
    input  logic               tpu_done,
    input  logic [3:0]         tpu_num,
    input  logic               tpu_overflow,
    output logic               result_valid,
    output logic [3:0]         result_num,
    output logic               result_overflow,
    output logic               timeout,
    output logic               busy
);

    localparam int IDX_W = $clog2(IMG_PIX);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RST_TPU,
        WAIT_TPU,
        RESULT
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic [15:0]        cnt;
    logic               beat;
    logic               rst_last;
    logic               wait_expired;

    assign beat         = pix_valid & pix_ready;
    assign rst_last     = (cnt == 16'(TPU_RST_CYC - 1));
    assign wait_expired = (cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pix_ready  = 1'b0;
        tpu_ena    = 1'b0;
        tpu_rst_n  = 1'b1;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                pix_ready = 1'b1;
                if (beat && pix_sof) next_state = FILL;
            end
            FILL: begin
                pix_ready = 1'b1;
                if (beat && !pix_sof && idx == IDX_W'(IMG_PIX - 1)) next_state = RST_TPU;
            end
            RST_TPU: begin
                tpu_ena   = 1'b1;
                tpu_rst_n = 1'b0;
                busy      = 1'b1;
                if (rst_last) next_state = WAIT_TPU;
            end
            WAIT_TPU: begin
                tpu_ena = 1'b1;
                busy    = 1'b1;
                if (tpu_done || wait_expired) next_state = RESULT;
            end
            RESULT: begin
                pix_ready = 1'b1;
                if (beat && pix_sof) next_state = FILL;
            end
            default: next_state = IDLE;
        endcase
    end

    // The shared cycle counter restarts on every state change, so it counts
    // from zero in both RST_TPU and WAIT_TPU.
    always_ff @(posedge clk) begin
        if (iRst) begin
            image_out       <= '0;
            idx             <= '0;
            cnt             <= '0;
            result_valid    <= 1'b0;
            result_num      <= 4'h0;
            result_overflow <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            if (state != next_state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
            case (state)
                IDLE, RESULT: begin
                    if (beat && pix_sof) begin
                        image_out[0] <= pix_data;
                        idx          <= IDX_W'(1);
                        result_valid <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end
                FILL: begin
                    if (beat) begin
                        if (pix_sof) begin
                            image_out[0] <= pix_data;
                            idx          <= IDX_W'(1);
                        end else begin
                            image_out[idx] <= pix_data;
                            idx            <= idx + IDX_W'(1);
                        end
                    end
                end
                WAIT_TPU: begin
                    // A done in the same cycle as expiry takes priority.
                    if (tpu_done) begin
                        result_num      <= tpu_num;
                        result_overflow <= tpu_overflow;
                        result_valid    <= 1'b1;
                    end else if (wait_expired) begin
                        result_num      <= 4'hF;
                        result_overflow <= 1'b0;
                        timeout         <= 1'b1;
                        result_valid    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_image_frame_loader.sv
// Directed testbench for image_frame_loader: frame assembly, TPU handshake,
// timeout, mid-run reset and back-to-back frames.
module tb_image_frame_loader;

    logic          clk;
    logic          iRst;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_data;
    logic          pix_sof;
    logic [1023:0] image_out;
    logic          tpu_ena;
    logic          tpu_rst_n;
    logic          tpu_done;
    logic [3:0]    tpu_num;
    logic          tpu_overflow;
    logic          result_valid;
    logic [3:0]    result_num;
    logic          result_overflow;
    logic          timeout;
    logic          busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    bit early_busy;

    image_frame_loader #(
        .IMG_PIX    (1024),
        .TPU_RST_CYC(2),
        .TIMEOUT    (100)
    ) dut (
        .clk            (clk),
        .iRst           (iRst),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_data       (pix_data),
        .pix_sof        (pix_sof),
        .image_out      (image_out),
        .tpu_ena        (tpu_ena),
        .tpu_rst_n      (tpu_rst_n),
        .tpu_done       (tpu_done),
        .tpu_num        (tpu_num),
        .tpu_overflow   (tpu_overflow),
        .result_valid   (result_valid),
        .result_num     (result_num),
        .result_overflow(result_overflow),
        .timeout        (timeout),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic patBit(input int p, input int k);
        case (p)
            0:       return logic'(((k >> 5) ^ k) & 1);
            1:       return logic'((k % 3) == 0);
            2:       return logic'(((k * 37 + 5) >> 2) & 1);
            default: return logic'(((k >> 3) + (k >> 7)) & 1);
        endcase
    endfunction

    function automatic logic [1023:0] expImage(input int p);
        logic [1023:0] img;
        for (int k = 0; k < 1024; k++) img[k] = patBit(p, k);
        return img;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic d, input logic s);
        pix_valid = v;
        pix_data  = d;
        pix_sof   = s;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkImage(input string tag, input logic [1023:0] expected);
        int first;
        first = -1;
        for (int k = 1023; k >= 0; k--) if (image_out[k] !== expected[k]) first = k;
        checks++;
        assert (image_out === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s first bad bit %0d observed=%b expected=%b",
                   tag, first, image_out[first], expected[first]);
        end
    endtask

    // Sends n beats of pattern p, sof on the first; optional random idle gaps
    // carry garbage data/sof with valid low.
    task automatic sendFrame(input int p, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                pix_data  = 1'b1;
                pix_sof   = 1'b1;
                repeat ($urandom_range(1, 2)) tick();
            end
            if (busy !== 1'b0 || pix_ready !== 1'b1) early_busy = 1'b1;
            applyStimulus(1'b1, patBit(p, k), k == 0);
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = 1'b0;
    endtask

    // Called right after the last beat; measures the TPU reset pulse, then
    // either answers after delay WAIT cycles or never answers.
    task automatic runTpu(input int delay, input logic [3:0] num, input logic ovf,
                          input bit never);
        int low;
        low = 0;
        while (tpu_rst_n === 1'b0 && low < 10) begin
            low++;
            tick();
        end
        checkOutput("rst_n_low_cycles", low, 2);
        checkOutput("wait_ena", {tpu_ena, tpu_rst_n, busy}, 3'b111);
        tpu_num      = num;
        tpu_overflow = ovf;
        if (never) begin
            repeat (99) tick();
            checkOutput("pre_timeout_valid", {result_valid, timeout, busy}, 3'b001);
            tick();
        end else begin
            repeat (delay) tick();
            checkOutput("pre_done_valid", result_valid, 0);
            tpu_done = 1'b1;
            tick();
            tpu_done = 1'b0;
        end
    endtask

    initial begin
        iRst         = 1'b1;
        pix_valid    = 1'b0;
        pix_data     = 1'b0;
        pix_sof      = 1'b0;
        tpu_done     = 1'b0;
        tpu_num      = 4'h0;
        tpu_overflow = 1'b0;
        repeat (2) tick();
        iRst = 1'b0;
        tick();
        checkOutput("reset_ctrl", {pix_ready, tpu_ena, tpu_rst_n, busy}, 4'b1010);
        checkOutput("reset_result", {result_valid, result_num, result_overflow, timeout}, 7'h00);
        checkImage("reset_image", '0);

        // T1: full frame, TPU answers 7 after 50 cycles
        early_busy = 1'b0;
        sendFrame(0, 1024, 1'b0);
        checkOutput("t1_no_early_busy", early_busy, 0);
        checkOutput("t1_rst_tpu", {busy, pix_ready, tpu_ena, tpu_rst_n}, 4'b1010);
        checkImage("t1_image", expImage(0));
        runTpu(50, 4'd7, 1'b0, 1'b0);
        checkOutput("t1_result", {result_valid, result_num, result_overflow, timeout}, {1'b1, 4'd7, 2'b00});
        checkOutput("t1_idle_ctrl", {busy, tpu_ena, tpu_rst_n, pix_ready}, 4'b0011);
        applyStimulus(1'b1, 1'b1, 1'b0);
        pix_valid = 1'b0;
        checkOutput("t1_held", {result_valid, result_num}, {1'b1, 4'd7});
        checkImage("t1_image_held", expImage(0));

        // T2: sof restart at beat 500
        early_busy = 1'b0;
        sendFrame(1, 500, 1'b0);
        checkOutput("t2_partial", {result_valid, busy}, 2'b00);
        sendFrame(2, 1024, 1'b0);
        checkOutput("t2_no_early_busy", early_busy, 0);
        checkOutput("t2_busy", busy, 1);
        checkImage("t2_image", expImage(2));
        runTpu(10, 4'd3, 1'b0, 1'b0);
        checkOutput("t2_result", {result_valid, result_num}, {1'b1, 4'd3});

        // T3: garbage in IDLE, gapped frame
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        pix_valid = 1'b0;
        checkImage("t3_idle_garbage", '0);
        early_busy = 1'b0;
        sendFrame(3, 1024, 1'b1);
        checkOutput("t3_no_early_busy", early_busy, 0);
        checkImage("t3_image", expImage(3));
        runTpu(20, 4'd5, 1'b1, 1'b0);
        checkOutput("t3_result", {result_valid, result_num, result_overflow}, {1'b1, 4'd5, 1'b1});

        // T4: TPU never finishes
        sendFrame(1, 1024, 1'b0);
        runTpu(0, 4'd2, 1'b1, 1'b1);
        checkOutput("t4_timeout", {result_valid, result_num, result_overflow, timeout}, {1'b1, 4'hF, 2'b01});
        checkOutput("t4_busy", {busy, tpu_ena}, 2'b00);
        checkImage("t4_image", expImage(1));

        // T6: back-to-back frames
        sendFrame(0, 1, 1'b0);
        checkOutput("t6_sof_clears", {result_valid, timeout}, 2'b00);
        sendFrame(0, 1024, 1'b0);
        runTpu(5, 4'd3, 1'b0, 1'b0);
        checkOutput("t6_first", {result_valid, result_num, result_overflow}, {1'b1, 4'd3, 1'b0});
        sendFrame(2, 1, 1'b0);
        checkOutput("t6_valid_drop", result_valid, 0);
        sendFrame(2, 1024, 1'b0);
        runTpu(8, 4'd9, 1'b1, 1'b0);
        checkOutput("t6_second", {result_valid, result_num, result_overflow}, {1'b1, 4'd9, 1'b1});

        // T5: reset in the middle of WAIT_TPU
        sendFrame(3, 1024, 1'b0);
        repeat (7) tick();
        checkOutput("t5_in_wait", {busy, tpu_ena, tpu_rst_n}, 3'b111);
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        checkOutput("t5_ctrl", {tpu_ena, tpu_rst_n, result_valid, pix_ready, busy}, 5'b01010);
        checkImage("t5_image", '0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
